// File: rtl/mem_resp.sv
// Word-addressed memory responder: accepts one load/store request, waits LATENCY
// cycles, then answers with a one-cycle Ack carrying aligned load data or an error flag.
module mem_resp #(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic        Req_We,
  input  logic [31:0] Req_Addr,
  input  logic [3:0]  Req_Byte_En,
  input  logic [31:0] Req_WData,
  input  logic [2:0]  Req_Load_Op,
  output logic        Ack,
  output logic [31:0] RData,
  output logic        Addr_Err,
  output logic        Busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        capture;

  logic          we_q;
  logic [AW+1:0] addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [2:0]    op_q;

  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0] word, merged, resp_data;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        be_ok, resp_err, wr_en, finish;
  logic        addr_unused;

  // Address bits above the array span are deliberately dropped (wrap-around).
  assign addr_unused = ^Req_Addr[31:AW+2];

  assign Busy   = (state != IDLE);
  assign Ack    = (state == RESP);
  assign finish = (state == WAIT) && (cnt == '0);
  assign idx    = addr_q[AW+1:2];
  assign word   = mem[idx];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      IDLE: if (Req) begin
        capture  = 1'b1;
        cnt_nx   = 4'(LATENCY - 1);
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nx = RESP;
        else           cnt_nx   = cnt - 4'd1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    case (be_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                   be_ok = 1'b0;
    endcase
  end

  always_comb begin
    resp_data = '0;
    resp_err  = 1'b0;
    wr_en     = 1'b0;
    merged    = word;
    half_v    = addr_q[1] ? word[31:16] : word[15:0];
    case (addr_q[1:0])
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    for (int unsigned i = 0; i < 4; i++)
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];

    if (we_q) begin
      resp_err = !be_ok;
      wr_en    = be_ok;
    end else begin
      case (op_q)
        3'b001: resp_data = {24'h0, byte_v};
        3'b010: resp_data = {{24{byte_v[7]}}, byte_v};
        3'b011, 3'b100: begin
          if (addr_q[0])            resp_err  = 1'b1;
          else if (op_q == 3'b100)  resp_data = {{16{half_v[15]}}, half_v};
          else                      resp_data = {16'h0, half_v};
        end
        default: begin
          if (addr_q[1:0] != 2'b00) resp_err  = 1'b1;
          else                      resp_data = word;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      RData    <= '0;
      Addr_Err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (capture) begin
        we_q    <= Req_We;
        addr_q  <= Req_Addr[AW+1:0];
        be_q    <= Req_Byte_En;
        wdata_q <= Req_WData;
        op_q    <= Req_Load_Op;
      end
      if (finish) begin
        RData    <= resp_data;
        Addr_Err <= resp_err;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[AW'(i)] <= '0;
    end else if (finish && wr_en) begin
      mem[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: directed scenarios plus random traffic against a byte-array model.
module tb_mem_resp;

  localparam int unsigned LAT = 2;

  logic        Clk, Rst, Req, Req_We;
  logic [31:0] Req_Addr, Req_WData;
  logic [3:0]  Req_Byte_En;
  logic [2:0]  Req_Load_Op;
  logic        Ack, Addr_Err, Busy;
  logic [31:0] RData;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_ack = 0;
  logic [31:0] got_rd;
  logic        got_err;
  logic [7:0]  mb [4096];

  mem_resp #(.LATENCY(LAT), .DEPTH_WORDS(1024)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Req_We(Req_We), .Req_Addr(Req_Addr),
    .Req_Byte_En(Req_Byte_En), .Req_WData(Req_WData), .Req_Load_Op(Req_Load_Op),
    .Ack(Ack), .RData(RData), .Addr_Err(Addr_Err), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
  endtask

  // Byte-granular reference: memory is 4096 bytes; loads assembled little-endian.
  task automatic model_access(input logic we, input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] wd, input logic [2:0] op,
                              output logic [31:0] rd, output logic err);
    logic [11:0] b, base;
    logic [7:0]  bt;
    logic [15:0] hw;
    b    = a[11:0];
    base = {b[11:2], 2'b00};
    rd   = 32'h0;
    err  = 1'b0;
    if (we) begin
      if (be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mb[int'(base) + i] = wd[8*i +: 8];
      end else err = 1'b1;
    end else begin
      bt = mb[b];
      hw = {mb[{b[11:1], 1'b1}], mb[{b[11:1], 1'b0}]};
      case (op)
        3'b001: rd = 32'(bt);
        3'b010: rd = 32'(signed'(bt));
        3'b011: if (b[0]) err = 1'b1; else rd = 32'(hw);
        3'b100: if (b[0]) err = 1'b1; else rd = 32'(signed'(hw));
        default:
          if (b[1:0] != 2'b00) err = 1'b1;
          else rd = {mb[base + 12'd3], mb[base + 12'd2], mb[base + 12'd1], mb[base]};
      endcase
    end
  endtask

  // One request starting at the next falling edge (DUT idle); returns #1 into the
  // idle cycle after Ack. hold keeps Req high for a back-to-back request; toggle
  // scrambles the request inputs during WAIT.
  task automatic access(input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [2:0] op,
                        input logic hold, input logic toggle);
    logic [31:0] exp_rd;
    logic        exp_err;
    model_access(we, a, be, wd, op, exp_rd, exp_err);
    @(negedge Clk);
    Req = 1'b1; Req_We = we; Req_Addr = a; Req_Byte_En = be; Req_WData = wd; Req_Load_Op = op;
    for (int k = 1; k <= int'(LAT) + 1; k++) begin
      @(posedge Clk); #1;
      chk("ack_timing", 32'(Ack), 32'(k == int'(LAT) + 1));
      chk("busy_active", 32'(Busy), 32'h1);
      if (k <= int'(LAT) && toggle) begin
        @(negedge Clk);
        Req = 1'($urandom); Req_We = 1'($urandom); Req_Addr = $urandom;
        Req_Byte_En = 4'($urandom); Req_WData = $urandom; Req_Load_Op = 3'($urandom);
      end
    end
    got_rd  = RData;
    got_err = Addr_Err;
    last_ack = cyc;
    chk("rdata", RData, exp_rd);
    chk("addr_err", 32'(Addr_Err), 32'(exp_err));
    @(negedge Clk);
    Req = hold; Req_We = we; Req_Addr = a; Req_Byte_En = be; Req_WData = wd; Req_Load_Op = op;
    @(posedge Clk); #1;
    chk("ack_single", 32'(Ack), 32'h0);
    chk("busy_idle", 32'(Busy), 32'h0);
    chk("rdata_held", RData, exp_rd);
  endtask

  initial begin
    int prev_ack;
    logic [31:0] a;
    logic [3:0] be_tab [8];
    be_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0101};
    Rst = 1'b1; Req = 1'b0; Req_We = 1'b0; Req_Addr = '0;
    Req_Byte_En = '0; Req_WData = '0; Req_Load_Op = '0;
    model_clear();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_ack", 32'(Ack), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_rdata", RData, 32'h0);
    chk("rst_err", 32'(Addr_Err), 32'h0);
    Rst = 1'b0;

    access(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 3'b000, 1'b0, 1'b0);
    chk("st_rdata", got_rd, 32'h0);
    access(1'b0, 32'h10, 4'b0000, 32'h0, 3'b000, 1'b0, 1'b0);
    chk("lw_10", got_rd, 32'hDEADBEEF);
    access(1'b0, 32'h13, 4'b0000, 32'h0, 3'b010, 1'b0, 1'b0);
    chk("lb_13", got_rd, 32'hFFFFFFDE);
    access(1'b0, 32'h13, 4'b0000, 32'h0, 3'b001, 1'b0, 1'b0);
    chk("lbu_13", got_rd, 32'h000000DE);
    access(1'b0, 32'h12, 4'b0000, 32'h0, 3'b100, 1'b0, 1'b0);
    chk("lh_12", got_rd, 32'hFFFFDEAD);
    access(1'b0, 32'h10, 4'b0000, 32'h0, 3'b011, 1'b0, 1'b0);
    chk("lhu_10", got_rd, 32'h0000BEEF);
    access(1'b1, 32'h10, 4'b0100, 32'h00AA0000, 3'b000, 1'b0, 1'b0);
    access(1'b0, 32'h10, 4'b0000, 32'h0, 3'b000, 1'b0, 1'b0);
    chk("lw_merge", got_rd, 32'hDEAABEEF);
    access(1'b0, 32'h11, 4'b0000, 32'h0, 3'b000, 1'b0, 1'b0);
    chk("lw_misalign_err", 32'(got_err), 32'h1);
    chk("lw_misalign_rd", got_rd, 32'h0);
    access(1'b1, 32'h10, 4'b0101, 32'h11223344, 3'b000, 1'b0, 1'b0);
    chk("st_badbe_err", 32'(got_err), 32'h1);
    access(1'b0, 32'h10, 4'b0000, 32'h0, 3'b000, 1'b0, 1'b0);
    chk("lw_after_badbe", got_rd, 32'hDEAABEEF);
    access(1'b1, 32'hFFFF_F010, 4'b0011, 32'h0000CAFE, 3'b000, 1'b0, 1'b0);
    access(1'b0, 32'h10, 4'b0000, 32'h0, 3'b000, 1'b0, 1'b0);
    chk("lw_wrap", got_rd, 32'hDEAACAFE);

    // Reset during WAIT of a store: aborted, no write, no Ack.
    @(negedge Clk);
    Req = 1'b1; Req_We = 1'b1; Req_Addr = 32'h20; Req_Byte_En = 4'b1111; Req_WData = 32'h12345678;
    @(posedge Clk); #1;
    chk("wait_busy", 32'(Busy), 32'h1);
    @(negedge Clk);
    Req = 1'b0; Rst = 1'b1;
    for (int k = 0; k < int'(LAT) + 2; k++) begin
      @(posedge Clk); #1;
      chk("rst_no_ack", 32'(Ack), 32'h0);
    end
    model_clear();
    Rst = 1'b0;
    chk("post_rst_busy", 32'(Busy), 32'h0);
    chk("post_rst_rdata", RData, 32'h0);
    chk("post_rst_err", 32'(Addr_Err), 32'h0);
    access(1'b0, 32'h20, 4'b0000, 32'h0, 3'b000, 1'b0, 1'b0);
    chk("lw_20_cleared", got_rd, 32'h0);
    access(1'b0, 32'h10, 4'b0000, 32'h0, 3'b000, 1'b0, 1'b0);
    chk("lw_10_cleared", got_rd, 32'h0);

    // Back-to-back with Req held through Ack, inputs scrambled during WAIT.
    access(1'b1, 32'h40, 4'b1111, 32'hA5A5_0F0F, 3'b000, 1'b1, 1'b1);
    prev_ack = last_ack;
    for (int n = 0; n < 4; n++) begin
      access(1'(n % 2), 32'h40 + 32'(4 * n), 4'b1111, $urandom, 3'b000, 1'(n < 3), 1'b1);
      chk("b2b_spacing", 32'(last_ack - prev_ack), 32'(LAT + 2));
      prev_ack = last_ack;
    end

    // Random traffic over a small window with random upper address bits.
    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      a[11:0] = 12'($urandom_range(0, 63));
      access(1'($urandom_range(0, 1)), a, be_tab[$urandom_range(0, 7)], $urandom,
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(negedge Clk);
    Req = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
